// File: rtl/hex_sample_rx.sv
// UART hex-line sample receiver: parses fixed-width hex lines into a FIFO, releases one per tick.
// Optional HEX_SAMPLE_RX_LOWERCASE_EN: accept 'a'-'f' as hex digits.
module hex_sample_rx #(
    parameter int DIGITS     = 6,
    parameter int FIFO_DEPTH = 16,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rvalid,
    output logic                          rready,
    input  logic [7:0]                    rdata,
    output logic [4*DIGITS-1:0]           sample_out,
    output logic                          sample_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err,
    output logic                          underrun
);

    localparam int W  = 4 * DIGITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(SAMPLE_DIV - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DIGIT, TERM, SKIP} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          push_q, push_d;
    logic          rdy_q;

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [W-1:0]  sample_q, sample_d;
    logic          valid_q, valid_d;
    logic          under_q, under_d;

    logic          is_hex, is_eol, fire, full, empty, tick_hit, pop;
    logic [3:0]    hex_val;

    always_comb begin
        is_eol  = (rdata == 8'h0D) || (rdata == 8'h0A);
        is_hex  = 1'b0;
        hex_val = 4'd0;
        if (rdata >= 8'h30 && rdata <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = rdata[3:0];
        end else if (rdata >= 8'h41 && rdata <= 8'h46) begin
            is_hex  = 1'b1;
            hex_val = rdata[3:0] + 4'd9;
        end
`ifdef HEX_SAMPLE_RX_LOWERCASE_EN
        else if (rdata >= 8'h61 && rdata <= 8'h66) begin
            is_hex  = 1'b1;
            hex_val = rdata[3:0] + 4'd9;
        end
`endif
    end

    assign full   = (level_q == FULL_LVL);
    assign empty  = (level_q == '0);
    // Backpressure only while holding a complete line that has nowhere to go
    assign rready = rdy_q && !(state_q == TERM && full);
    assign fire   = rvalid && rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            push_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            push_q  <= push_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fire) begin
            unique case (state_q)
                IDLE: begin
                    if (is_hex)       state_d = (DIGITS == 1) ? TERM : DIGIT;
                    else if (!is_eol) state_d = SKIP;
                end
                DIGIT: begin
                    if (is_hex) begin
                        if (cnt_q == LAST_CNT) state_d = TERM;
                    end else if (is_eol) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SKIP;
                    end
                end
                TERM:    state_d = is_eol ? IDLE : SKIP;
                SKIP:    if (is_eol) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        push_d = 1'b0;
        if (fire) begin
            unique case (state_q)
                IDLE: begin
                    if (is_hex) begin
                        acc_d = W'(hex_val);
                        cnt_d = CW'(1);
                    end else if (!is_eol) begin
                        err_d = 1'b1;
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end
                DIGIT: begin
                    if (is_hex) begin
                        acc_d = (acc_q << 4) | W'(hex_val);
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end
                TERM: begin
                    cnt_d = '0;
                    if (is_eol) begin
                        push_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        acc_d = '0;
                    end
                end
                SKIP:    err_d = is_eol;
                default: ;
            endcase
        end
    end

    // Push lands one cycle after the terminator, while acc_q still holds the line
    always_ff @(posedge clk) begin
        if (push_q) mem_q[wptr_q] <= acc_q;
    end

    always_comb begin
        tick_hit = (tick_q == LAST_TICK);
        tick_d   = tick_hit ? '0 : tick_q + TW'(1);
        pop      = tick_hit && !empty;
        wptr_d   = wptr_q + AW'(push_q);
        rptr_d   = rptr_q + AW'(pop);
        level_d  = level_q + LW'(push_q) - LW'(pop);
        sample_d = pop ? mem_q[rptr_q] : sample_q;
        valid_d  = pop;
        if (tick_hit && empty) under_d = 1'b1;
        else if (push_q)       under_d = 1'b0;
        else                   under_d = under_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            tick_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            tick_q   <= tick_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            under_q  <= under_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign fifo_level   = level_q;
    assign err          = err_q;
    assign underrun     = under_q;

endmodule

// File: tb/tb_hex_sample_rx.sv
// Self-checking bench for hex_sample_rx: vector table plus multi-cycle sequences.
// Expected samples go into a queue on send and are popped on each sample_valid.
module tb_hex_sample_rx;

    localparam int DIGITS = 6;
    localparam int DEPTH  = 4;
    localparam int DIV    = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        rvalid;
    logic        rready;
    logic [7:0]  rdata;
    logic [23:0] sample_out;
    logic        sample_valid;
    logic [2:0]  fifo_level;
    logic        err;
    logic        underrun;

    hex_sample_rx #(.DIGITS(DIGITS), .FIFO_DEPTH(DEPTH), .SAMPLE_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .sample_out(sample_out), .sample_valid(sample_valid),
        .fifo_level(fifo_level), .err(err), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       txt;
        bit          ok;
        logic [23:0] val;
        int          nerr;
    } vec_t;

    vec_t        vecs[$];
    logic [23:0] sb[$];
    int          nchk = 0;
    int          nfail = 0;
    int          err_cnt = 0;
    logic [23:0] last_val = '0;
    int          tcnt;

    // release-tick phase reference: ticks fire every DIV edges after reset
    always @(posedge clk or posedge rst) begin
        if (rst) tcnt <= 0;
        else     tcnt <= (tcnt == DIV - 1) ? 0 : tcnt + 1;
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        logic [23:0] e;
        @(negedge clk);
        if (!rst) begin
            if (err) err_cnt++;
            if (sample_valid) begin
                if (sb.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_sample: got %0h required none", sample_out);
                end else begin
                    e = sb.pop_front();
                    check("sample", 32'(sample_out), 32'(e));
                    last_val = e;
                end
            end
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        int n = 0;
        rvalid = 1'b1;
        rdata  = b;
        while (!rready && n < 3 * DIV) begin
            step();
            n++;
        end
        if (n >= 3 * DIV) begin
            nchk++;
            nfail++;
            $display("FAIL send_timeout: got rready 0 required 1 byte %0h", b);
        end else begin
            step();
        end
        rvalid = 1'b0;
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_drain(int lim);
        int n = 0;
        while (sb.size() != 0 && n < lim) begin
            step();
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic align();
        while (tcnt != 0) step();
    endtask

    task automatic add_vec(string t, bit ok, logic [23:0] v, int ne);
        vec_t x;
        x.txt = t; x.ok = ok; x.val = v; x.nerr = ne;
        vecs.push_back(x);
    endtask

    initial begin
        int e0;
        add_vec("0A3F9C\n",   1, 24'h0A3F9C, 0);
        add_vec("12G456\n",   0, 24'h0,      2);
        add_vec("1234\n",     0, 24'h0,      1);
        add_vec("1234567\n",  0, 24'h0,      2);
        add_vec("\r\n\n\r",   0, 24'h0,      0);
        add_vec("FFFFFF\r\n", 1, 24'hFFFFFF, 0);
        add_vec("000001\n",   1, 24'h000001, 0);
        add_vec("xyz\n",      0, 24'h0,      2);
        add_vec("12345\r",    0, 24'h0,      1);
        add_vec("ABCDEF0\r",  0, 24'h0,      2);
`ifdef HEX_SAMPLE_RX_LOWERCASE_EN
        add_vec("fedcba\n",   1, 24'hFEDCBA, 0);
`else
        add_vec("fedcba\n",   0, 24'h0,      2);
`endif

        rst = 1'b1;
        rvalid = 1'b0;
        rdata = 8'h00;
        step();
        step();
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        step();
        check("rready_after_rst", 32'(rready), 32'd1);

        foreach (vecs[k]) begin
            e0 = err_cnt;
            send_str(vecs[k].txt);
            if (vecs[k].ok) sb.push_back(vecs[k].val);
            repeat (3) step();
            check($sformatf("err_count_v%0d", k), 32'(err_cnt - e0), 32'(vecs[k].nerr));
            wait_drain(3 * DIV);
            check($sformatf("hold_v%0d", k), 32'(sample_out), 32'(last_val));
        end

        e0 = err_cnt;
        send_str("123456\r\nABCDEF\n");
        sb.push_back(24'h123456);
        sb.push_back(24'hABCDEF);
        wait_drain(4 * DIV);
        check("b2b_err", 32'(err_cnt - e0), 32'd0);

        align();
        e0 = err_cnt;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            sb.push_back(24'h111111 * 24'(i));
            if (i <= DEPTH) send_str($sformatf("%06h\n", 24'h111111 * 24'(i)));
            else send_str($sformatf("%06h", 24'h111111 * 24'(i)));
        end
        check("fill_level", 32'(fifo_level), 32'(DEPTH));
        check("fill_rready", 32'(rready), 32'd0);
        send_byte(8'h0A);
        check("fill_rready_back", 32'(rready), 32'd1);
        wait_drain(8 * DIV);
        check("fill_err", 32'(err_cnt - e0), 32'd0);

        repeat (2 * DIV + 2) step();
        check("underrun_set", 32'(underrun), 32'd1);
        check("underrun_hold", 32'(sample_out), 32'h555555);
        align();
        send_str("00FFFF\n");
        sb.push_back(24'h00FFFF);
        repeat (3) step();
        check("underrun_clear", 32'(underrun), 32'd0);
        wait_drain(3 * DIV);

        align();
        send_str("12");
        rst = 1'b1;
        #1;
        check("midrst_rready", 32'(rready), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_sample", 32'(sample_out), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("midrst_rready_up", 32'(rready), 32'd1);
        e0 = err_cnt;
        send_str("abcdef\n");
`ifdef HEX_SAMPLE_RX_LOWERCASE_EN
        sb.push_back(24'hABCDEF);
        repeat (3) step();
        check("midrst_err", 32'(err_cnt - e0), 32'd0);
`else
        repeat (3) step();
        check("midrst_err", 32'(err_cnt - e0), 32'd2);
`endif
        wait_drain(3 * DIV);

        repeat (2 * DIV) step();
        check("final_queue", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/hex_sample_rx.md
HEX_SAMPLE_RX -- requirements
Module: hex_sample_rx

Interface
REQ-001 Parameter DIGITS, default 6: hex digits per sample line; sample width is 4*DIGITS bits.
REQ-002 Parameter FIFO_DEPTH, default 16: decoded-sample buffer depth; power of two, at least 2.
REQ-003 Parameter SAMPLE_DIV, default 1024: clk cycles between sample releases; at least 2.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port rvalid, input, 1: a received UART byte is available.
REQ-007 Port rready, output, 1: this block accepts the byte; transfer occurs when rvalid and rready are both high.
REQ-008 Port rdata, input, 8: received ASCII byte.
REQ-009 Port sample_out, output, 4*DIGITS: last released sample; feeds the DAC input.
REQ-010 Port sample_valid, output, 1: one-cycle pulse marking a new sample_out value.
REQ-011 Port fifo_level, output, $clog2(FIFO_DEPTH)+1: number of buffered samples.
REQ-012 Port err, output, 1: one-cycle pulse on each malformed line.
REQ-013 Port underrun, output, 1: sticky flag, set when a release tick finds the FIFO empty.

Function
REQ-014 The parser SHALL have four states: IDLE, DIGIT, TERM and SKIP.
REQ-015 IDLE: CR (0x0D) and LF (0x0A) are consumed and ignored, so CRLF and LFCR produce no empty samples.
REQ-016 IDLE: a hex digit clears the accumulator, loads the digit, sets the digit count to 1 and moves to DIGIT (TERM if DIGITS=1).
REQ-017 Hex digits are 0x30-0x39 (value 0-9) and 0x41-0x46 (value 10-15); each accepted digit shifts the accumulator left 4 and inserts its value, most significant digit first.
REQ-018 DIGIT: the parser moves to TERM when the count reaches DIGITS.
REQ-019 TERM: CR or LF pushes the accumulator into the FIFO on the following cycle and returns to IDLE.
REQ-020 Error conditions:
- a non-hex byte in IDLE, DIGIT or TERM;
- CR or LF in DIGIT (short line);
- a hex digit in TERM (long line).
REQ-021 On an error condition the parser SHALL pulse err for one cycle, discard the accumulator and enter SKIP; in SKIP it leaves on CR or LF, which also pulses err.
REQ-022 rready SHALL be high in every state except when the parser is in TERM and the FIFO is full; this is lossless backpressure, and no sample is dropped.
REQ-023 A free-running tick counter SHALL count 0..SAMPLE_DIV-1 from reset.
REQ-024 At count SAMPLE_DIV-1 with the FIFO non-empty, the block SHALL pop, register the value onto sample_out and pulse sample_valid in the next cycle.
REQ-025 At count SAMPLE_DIV-1 with the FIFO empty, the block SHALL hold sample_out, keep sample_valid low and set underrun.
REQ-026 underrun SHALL clear only on the first sample accepted into the FIFO after the flag was set.
REQ-027 On a simultaneous push and pop, fifo_level SHALL be unchanged and the data stays ordered; a push into a full FIFO cannot occur (see REQ-022).
REQ-028 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 While rst is high, all state SHALL clear asynchronously:
- parser to IDLE, accumulator and digit count 0;
- FIFO empty, fifo_level 0;
- tick counter 0;
- sample_out 0;
- sample_valid, err and underrun 0;
- rready 0.
REQ-030 A partially received line at reset SHALL be lost; after release rready goes high on the first clk edge and parsing restarts in IDLE.

Configuration
REQ-031 Macro HEX_SAMPLE_RX_LOWERCASE_EN defined: bytes 0x61-0x66 SHALL be accepted as digit values 10-15.
REQ-032 Macro HEX_SAMPLE_RX_LOWERCASE_EN undefined: bytes 0x61-0x66 SHALL be non-hex and trigger the REQ-020/REQ-021 error handling.

Verification
REQ-033 Bytes "0A3F9C",LF, then wait one tick period -> sample_out=24'h0A3F9C, exactly one sample_valid pulse, err never pulses.
REQ-034 "123456",CR,LF,"ABCDEF",LF -> two samples released in order: 24'h123456, then 24'hABCDEF; no err pulse.
REQ-035 "12G456",LF -> one err pulse at 'G' and one at LF, nothing pushed. "1234",LF -> one err pulse. "1234567",LF -> two err pulses (at '7' and at LF).
REQ-036 Hold releases off and send FIFO_DEPTH+1 lines -> fifo_level reaches FIFO_DEPTH and rready drops at the final terminator; after the next release rready returns high and all FIFO_DEPTH+1 samples emerge in order.
REQ-037 No input for 2*SAMPLE_DIV cycles -> underrun=1 and sample_out unchanged. Then "00FFFF",LF -> underrun clears.
REQ-038 Assert rst after "12" of a line, then send "abcdef",LF:
- macro defined -> sample 24'hABCDEF released;
- macro undefined -> err pulses, no sample.
